// File: rtl/awgn_mon_pkg.sv
// awgn_mon_pkg: shared state encoding, default format and accumulator width helpers for the AWGN monitor
package awgn_mon_pkg;
  typedef enum logic [2:0] {IDLE, ACCUM, CALC1, CALC2, HOLD} state_t;
  localparam int FRAC_DEF = 11;
  function automatic int sum_w(input int dw, input int l);
    return dw + l + 1;
  endfunction
  function automatic int sumsq_w(input int dw, input int l);
    return 2 * dw + l;
  endfunction
endpackage

// File: rtl/awgn_mon_sq_acc.sv
// awgn_mon_sq_acc: one lane's running sum and running sum of squares over a full window
module awgn_mon_sq_acc
  import awgn_mon_pkg::*;
#(
  parameter int DW = 16,
  parameter int LOG2_N = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clr,
  input  logic                                 en,
  input  logic signed [DW-1:0]                 x,
  output logic signed [sum_w(DW, LOG2_N)-1:0]  sum,
  output logic [sumsq_w(DW, LOG2_N)-1:0]       sumsq
);
  localparam int SW = sum_w(DW, LOG2_N);
  localparam int QW = sumsq_w(DW, LOG2_N);
  localparam int PW = 2 * DW;
  logic [PW-1:0] sq;
  assign sq = PW'(x) * PW'(x);
  // accumulate sign-extended sample and zero-extended square while enabled
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      sum   <= '0;
      sumsq <= '0;
    end else if (en) begin
      sum   <= sum + {{(SW-DW){x[DW-1]}}, x};
      sumsq <= sumsq + {{(QW-PW){1'b0}}, sq};
    end
  end
endmodule

// File: rtl/awgn_stats_monitor.sv
// awgn_stats_monitor: windowed sum, sum of squares, mean and variance of two AWGN lanes; AWGN_MON_PEAK_EN adds peak tracking
module awgn_stats_monitor
  import awgn_mon_pkg::*;
#(
  parameter int DW = 16,
  parameter int FRAC = FRAC_DEF,
  parameter int LOG2_N = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic signed [DW-1:0]          x0,
  input  logic signed [DW-1:0]          x1,
  output logic                          busy,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic signed [DW+LOG2_N:0]     sum_out,
  output logic [2*DW+LOG2_N-1:0]        sumsq_out,
  output logic signed [DW-1:0]          mean_out,
  output logic [2*DW-1:0]               var_out
`ifdef AWGN_MON_PEAK_EN
  ,
  output logic signed [DW-1:0]          peak_max_out,
  output logic signed [DW-1:0]          peak_min_out
`endif
);
  localparam int SW = sum_w(DW, LOG2_N);
  localparam int QW = sumsq_w(DW, LOG2_N);
  localparam int PW = 2 * DW;
  if (FRAC >= DW) begin : g_frac_chk
    $error("FRAC must be smaller than DW");
  end
  state_t state, state_n;
  logic [LOG2_N-1:0] cnt;
  logic hs, clr, en;
  logic signed [SW-1:0] s0, s1, acc_sum;
  logic [QW-1:0] q0, q1, acc_sq;
  logic [PW-1:0] msq, mm;
  logic [PW:0] diff;
  assign hs        = state == HOLD && res_ready;
  assign clr       = start && (state == IDLE || hs);
  assign en        = state == ACCUM && in_valid;
  assign busy      = state == ACCUM || state == CALC1 || state == CALC2;
  assign res_valid = state == HOLD;
  assign acc_sum   = s0 + s1;
  assign acc_sq    = q0 + q1;
  assign mm        = PW'(mean_out) * PW'(mean_out);
  assign diff      = {1'b0, msq} - {1'b0, mm};
  awgn_mon_sq_acc #(.DW(DW), .LOG2_N(LOG2_N)) u_x0 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .x(x0), .sum(s0), .sumsq(q0)
  );
  awgn_mon_sq_acc #(.DW(DW), .LOG2_N(LOG2_N)) u_x1 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .x(x1), .sum(s1), .sumsq(q1)
  );
  // next state: window runs until the pair at the last count is accepted
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ACCUM : IDLE;
      ACCUM:   state_n = (en && &cnt) ? CALC1 : ACCUM;
      CALC1:   state_n = CALC2;
      CALC2:   state_n = HOLD;
      HOLD:    state_n = hs ? (start ? ACCUM : IDLE) : HOLD;
      default: state_n = IDLE;
    endcase
  end
  // state register and accepted-pair counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= clr ? '0 : en ? cnt + 1'b1 : cnt;
    end
  end
  // result registers: mean and mean square in CALC1, clamped variance in CALC2
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_out   <= '0;
      sumsq_out <= '0;
      mean_out  <= '0;
      msq       <= '0;
      var_out   <= '0;
    end else begin
      if (state == CALC1) begin
        sum_out   <= acc_sum;
        sumsq_out <= acc_sq;
        mean_out  <= acc_sum[DW+LOG2_N:LOG2_N+1];
        msq       <= {1'b0, acc_sq[QW-1:LOG2_N+1]};
      end
      if (state == CALC2) var_out <= diff[PW] ? '0 : diff[PW-1:0];
    end
  end
`ifdef AWGN_MON_PEAK_EN
  logic signed [DW-1:0] hi, lo;
  assign hi = x0 > x1 ? x0 : x1;
  assign lo = x0 > x1 ? x1 : x0;
  // running extremes over both lanes, preset to the opposite rails at window start
  always_ff @(posedge clk) begin
    if (!reset) begin
      peak_max_out <= '0;
      peak_min_out <= '0;
    end else if (clr) begin
      peak_max_out <= {1'b1, {(DW-1){1'b0}}};
      peak_min_out <= {1'b0, {(DW-1){1'b1}}};
    end else if (en) begin
      peak_max_out <= hi > peak_max_out ? hi : peak_max_out;
      peak_min_out <= lo < peak_min_out ? lo : peak_min_out;
    end
  end
`endif
endmodule

// File: tb/tb_awgn_stats_monitor.sv
// tb_awgn_stats_monitor: directed self-checking bench for awgn_stats_monitor with a 16-pair window
module tb_awgn_stats_monitor;
  localparam int DW = 16;
  localparam int L = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic res_ready = 1'b0;
  logic signed [DW-1:0] x0 = '0;
  logic signed [DW-1:0] x1 = '0;
  logic busy, res_valid;
  logic signed [DW+L:0] sum_out;
  logic [2*DW+L-1:0] sumsq_out;
  logic signed [DW-1:0] mean_out;
  logic [2*DW-1:0] var_out;
`ifdef AWGN_MON_PEAK_EN
  logic signed [DW-1:0] peak_max_out, peak_min_out;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  awgn_stats_monitor #(.DW(DW), .FRAC(11), .LOG2_N(L)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .x0(x0), .x1(x1), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .sum_out(sum_out), .sumsq_out(sumsq_out), .mean_out(mean_out), .var_out(var_out)
`ifdef AWGN_MON_PEAK_EN
    , .peak_max_out(peak_max_out), .peak_min_out(peak_min_out)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit gap, output int lat);
    start = 1'b1; in_valid = 1'b1; x0 = 16'h7FFF; x1 = 16'h7FFF;
    step;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; x0 = a; x1 = b;
      step;
      if (gap && i < 15) begin
        in_valid = 1'b0; x0 = 16'h7FFF; x1 = 16'h7FFF;
        step;
      end
    end
    in_valid = 1'b0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      step;
      lat++;
    end
  endtask

  task automatic accept;
    res_ready = 1'b1;
    step;
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step; step;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (sum_out !== '0 || sumsq_out !== '0) begin failures++; $display("FAIL reset_sums got=%h/%h exp=0/0", sum_out, sumsq_out); end
    checks++; if (mean_out !== '0 || var_out !== '0) begin failures++; $display("FAIL reset_mean_var got=%h/%h exp=0/0", mean_out, var_out); end
    reset = 1'b1;
    step;
  endtask

  task automatic test_dc;
    int lat;
    run_window(16'h0800, 16'h0800, 1'b0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL dc_latency got=%0d exp=2", lat); end
    checks++; if (sum_out !== 21'h10000) begin failures++; $display("FAIL dc_sum got=%h exp=10000", sum_out); end
    checks++; if (sumsq_out !== 36'h8000000) begin failures++; $display("FAIL dc_sumsq got=%h exp=8000000", sumsq_out); end
    checks++; if (mean_out !== 16'h0800) begin failures++; $display("FAIL dc_mean got=%h exp=0800", mean_out); end
    checks++; if (var_out !== 32'h0) begin failures++; $display("FAIL dc_var got=%h exp=0", var_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dc_busy_hold got=%b exp=0", busy); end
    accept;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL dc_idle got=%b/%b exp=0/0", res_valid, busy); end
    checks++; if (sum_out !== 21'h10000) begin failures++; $display("FAIL dc_idle_held got=%h exp=10000", sum_out); end
  endtask

  task automatic test_zero_mean;
    int lat;
    run_window(16'h0800, 16'hF800, 1'b0, lat);
    checks++; if (sum_out !== 21'h0) begin failures++; $display("FAIL zm_sum got=%h exp=0", sum_out); end
    checks++; if (sumsq_out !== 36'h8000000) begin failures++; $display("FAIL zm_sumsq got=%h exp=8000000", sumsq_out); end
    checks++; if (mean_out !== 16'h0) begin failures++; $display("FAIL zm_mean got=%h exp=0", mean_out); end
    checks++; if (var_out !== 32'h400000) begin failures++; $display("FAIL zm_var got=%h exp=400000", var_out); end
    accept;
  endtask

  task automatic test_gaps;
    int lat;
    run_window(16'h0400, 16'h0000, 1'b1, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL gap_latency got=%0d exp=2", lat); end
    checks++; if (sum_out !== 21'h4000) begin failures++; $display("FAIL gap_sum got=%h exp=4000", sum_out); end
    checks++; if (sumsq_out !== 36'h1000000) begin failures++; $display("FAIL gap_sumsq got=%h exp=1000000", sumsq_out); end
    checks++; if (mean_out !== 16'h0200) begin failures++; $display("FAIL gap_mean got=%h exp=0200", mean_out); end
    checks++; if (var_out !== 32'h40000) begin failures++; $display("FAIL gap_var got=%h exp=40000", var_out); end
  endtask

  task automatic test_hold_restart;
    start = 1'b1; res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step;
      checks++;
      if (res_valid !== 1'b1 || busy !== 1'b0 || sum_out !== 21'h4000 || var_out !== 32'h40000)
        begin failures++; $display("FAIL hold_stable cyc=%0d got=%b/%b/%h/%h exp=1/0/4000/40000", i, res_valid, busy, sum_out, var_out); end
    end
    res_ready = 1'b1;
    step;
    start = 1'b0; res_ready = 1'b0;
    checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL restart got=%b/%b exp=1/0", busy, res_valid); end
  endtask

  task automatic test_reset_abort;
    int lat;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; x0 = 16'h0100; x1 = 16'h0100;
      if (i == 6) reset = 1'b0;
      step;
    end
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL abort_state got=%b/%b exp=0/0", busy, res_valid); end
    checks++; if (sum_out !== '0 || sumsq_out !== '0 || mean_out !== '0 || var_out !== '0)
      begin failures++; $display("FAIL abort_outputs got=%h/%h/%h/%h exp=0", sum_out, sumsq_out, mean_out, var_out); end
    reset = 1'b1;
    step;
    run_window(16'h0800, 16'h0800, 1'b0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL clean_latency got=%0d exp=2", lat); end
    checks++; if (sum_out !== 21'h10000 || sumsq_out !== 36'h8000000) begin failures++; $display("FAIL clean_sums got=%h/%h exp=10000/8000000", sum_out, sumsq_out); end
    accept;
  endtask

  task automatic test_full_scale;
    int lat;
    run_window(16'h8000, 16'h8000, 1'b0, lat);
    checks++; if (sum_out !== 21'h100000) begin failures++; $display("FAIL fs_sum got=%h exp=100000", sum_out); end
    checks++; if (sumsq_out !== 36'h800000000) begin failures++; $display("FAIL fs_sumsq got=%h exp=800000000", sumsq_out); end
    checks++; if (mean_out !== 16'h8000) begin failures++; $display("FAIL fs_mean got=%h exp=8000", mean_out); end
    checks++; if (var_out !== 32'h0) begin failures++; $display("FAIL fs_var got=%h exp=0", var_out); end
`ifdef AWGN_MON_PEAK_EN
    checks++; if (peak_max_out !== 16'h8000 || peak_min_out !== 16'h8000) begin failures++; $display("FAIL fs_peaks got=%h/%h exp=8000/8000", peak_max_out, peak_min_out); end
`endif
    accept;
  endtask

  initial begin
    test_reset;
    test_dc;
    test_zero_mean;
    test_gaps;
    test_hold_restart;
    test_reset_abort;
    test_full_scale;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
